fp_serial_feeder: RTL

FP_SERIAL_FEEDER -- requirements
Module: fp_serial_feeder

---
 rtl/fp_serial_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fp_serial_feeder.sv
// Feeds one IEEE-754 operand pair, MSB first, into a bit-serial float adder.
// It then waits for the adder's done flag, with a bounded timeout.
module fp_serial_feeder #(
   parameter int unsigned TIMEOUT_CYCLES = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic        done_in,
   output logic        ready,
   output logic        busy,
   output logic        go,
   output logic        inpab,
   output logic        timeout_err
);

   localparam int unsigned BIT_W  = 5;
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SEND_A,
      SEND_B,
      WAIT_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               go_q, go_d;
   logic               inpab_q, inpab_d;
   logic               timeout_err_q, timeout_err_d;

   // State, counters, operands and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         wait_cnt_q    <= '0;
         a_q           <= '0;
         b_q           <= '0;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
         go_q          <= 1'b1;
         inpab_q       <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         a_q           <= a_d;
         b_q           <= b_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         go_q          <= go_d;
         inpab_q       <= inpab_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next state; outputs are derived from the next state so they line up with it
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      a_d           = a_q;
      b_d           = b_q;
      timeout_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d       = a_in;
               b_d       = b_in;
               bit_cnt_d = '0;
               state_d   = ARM;
            end
         end
         ARM: begin
            bit_cnt_d = '0;
            state_d   = SEND_A;
         end
         SEND_A: begin
            if (bit_cnt_q == BIT_W'(31)) begin
               bit_cnt_d = '0;
               state_d   = SEND_B;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         SEND_B: begin
            if (bit_cnt_q == BIT_W'(31)) begin
               bit_cnt_d  = '0;
               wait_cnt_d = '0;
               state_d    = WAIT_DONE;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         WAIT_DONE: begin
            // Timeout fires on the edge where the count reaches the limit; done wins a tie
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (done_in) begin
               wait_cnt_d = '0;
               state_d    = IDLE;
            end else if (wait_cnt_d == WAIT_W'(TIMEOUT_CYCLES)) begin
               wait_cnt_d    = '0;
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      go_d    = (state_d == IDLE);
      // ~bit_cnt selects bit 31-n, giving MSB-first order
      case (state_d)
         SEND_A:  inpab_d = a_d[~bit_cnt_d];
         SEND_B:  inpab_d = b_d[~bit_cnt_d];
         default: inpab_d = 1'b0;
      endcase
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign go          = go_q;
   assign inpab       = inpab_q;
   assign timeout_err = timeout_err_q;

endmodule
